// File: rtl/mips_pkg.sv
// Shared MEM-stage types: wait-FSM state, EX/MEM and MEM/WB bundles.
// The MEM/WB bundle is also consumed by the writeback stage.
package mips_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic        valid;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        misaligned;
        logic [4:0]  write_register;
        logic [31:0] alu_result;
        logic [31:0] write_data;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic        misaligned;
        logic        bus_error;
        logic [4:0]  write_register;
        logic [31:0] alu_result;
        logic [31:0] read_data;
    } mem_wb_t;

    localparam ex_mem_t M_BUBBLE = '{default: 1'b0};
    localparam mem_wb_t WB_RESET = '{default: 1'b0};
    localparam logic [1:0] WORD_ALIGNED = 2'b00;

    function automatic logic is_aligned_mem_op(input logic valid, input logic mem_read,
                                               input logic mem_write, input logic [1:0] addr_lsb);
        return valid & (mem_read | mem_write) & (addr_lsb == WORD_ALIGNED);
    endfunction

    function automatic logic is_misaligned_mem_op(input logic valid, input logic mem_read,
                                                  input logic mem_write, input logic [1:0] addr_lsb);
        return valid & (mem_read | mem_write) & (addr_lsb != WORD_ALIGNED);
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Request/wait-state controller for the MEM stage: tracks one outstanding
// memory request, raises stall while it waits and flags a timeout.
module mem_wait_fsm
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic capture_mem_op,
    input  logic mem_ack,
    output logic busy,
    output logic stall,
    output logic timeout
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    mem_state_e state_r;
    mem_state_e state_next_s;
    logic [7:0] cnt_r;
    logic       stall_s;
    logic       timeout_s;

    // Wait-state decode and next state. A timed-out request frees the stage
    // exactly like an ack, so an op captured on that edge still issues.
    always_comb begin
        stall_s      = 1'b0;
        timeout_s    = 1'b0;
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (capture_mem_op) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mem_ack || (cnt_r == CNT_LAST)) begin
                    timeout_s    = ~mem_ack;
                    state_next_s = capture_mem_op ? ST_BUSY : ST_IDLE;
                end else begin
                    stall_s      = 1'b1;
                    state_next_s = ST_BUSY;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Wait counter: restarts on every capture edge so each request gets a full budget
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if (stall_s) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= 8'd0;
        end
    end

    assign busy    = (state_r == ST_BUSY);
    assign stall   = stall_s;
    assign timeout = timeout_s;

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: holds the in-flight instruction (M), runs its load/store
// over the req/ack bus and presents a registered MEM/WB bundle.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Valid_EX,
    input  logic [31:0] ALU_Result_EX,
    input  logic [31:0] Write_Data_EX,
    input  logic [4:0]  Write_Register_EX,
    input  logic        MemRead_EX,
    input  logic        MemWrite_EX,
    input  logic        RegWrite_EX,
    input  logic        MemtoReg_EX,
    output logic        Stall_MEM,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_Wdata,
    input  logic [31:0] Mem_Rdata,
    input  logic        Mem_Ack,
    output logic        Valid_MEM,
    output logic        RegWrite_MEM,
    output logic        MemtoReg_MEM,
    output logic [31:0] ALU_Result_MEM,
    output logic [31:0] Read_Data_MEM,
    output logic [4:0]  Write_Register_MEM,
    output logic        Misaligned_MEM,
    output logic        Bus_Error_MEM
);

    ex_mem_t m_r;
    ex_mem_t m_next_s;
    mem_wb_t wb_r;
    mem_wb_t wb_next_s;
    logic    capture_mem_op_s;
    logic    busy_s;
    logic    stall_s;
    logic    timeout_s;
    logic    load_done_s;

    assign capture_mem_op_s = is_aligned_mem_op(Valid_EX, MemRead_EX, MemWrite_EX,
                                                ALU_Result_EX[1:0]);

    mem_wait_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_mem_wait_fsm (
        .clk           (Clk),
        .rst_n         (Reset_n),
        .capture_mem_op(capture_mem_op_s),
        .mem_ack       (Mem_Ack),
        .busy          (busy_s),
        .stall         (stall_s),
        .timeout       (timeout_s)
    );

    // EX bundle as it would enter M; a bubble clears every field
    always_comb begin
        m_next_s = M_BUBBLE;
        if (Valid_EX) begin
            m_next_s.valid          = 1'b1;
            m_next_s.mem_read       = MemRead_EX;
            m_next_s.mem_write      = MemWrite_EX;
            m_next_s.reg_write      = RegWrite_EX;
            m_next_s.mem_to_reg     = MemtoReg_EX;
            m_next_s.misaligned     = is_misaligned_mem_op(1'b1, MemRead_EX, MemWrite_EX,
                                                           ALU_Result_EX[1:0]);
            m_next_s.write_register = Write_Register_EX;
            m_next_s.alu_result     = ALU_Result_EX;
            m_next_s.write_data     = Write_Data_EX;
        end else begin
            m_next_s = M_BUBBLE;
        end
    end

    // M register: advances on every non-stalled edge
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_r <= M_BUBBLE;
        end else if (!stall_s) begin
            m_r <= m_next_s;
        end else begin
            m_r <= m_r;
        end
    end

    assign load_done_s = busy_s & Mem_Ack & m_r.mem_read;

    // Retire candidate. Stalled edges retire a bubble so fault flags and
    // Valid_MEM last exactly one cycle; data fields keep their last value.
    always_comb begin
        wb_next_s            = wb_r;
        wb_next_s.valid      = 1'b0;
        wb_next_s.reg_write  = 1'b0;
        wb_next_s.mem_to_reg = 1'b0;
        wb_next_s.misaligned = 1'b0;
        wb_next_s.bus_error  = 1'b0;
        if (!stall_s) begin
            wb_next_s.valid          = m_r.valid;
            wb_next_s.reg_write      = m_r.reg_write & ~m_r.misaligned & ~timeout_s;
            wb_next_s.mem_to_reg     = m_r.mem_to_reg;
            wb_next_s.misaligned     = m_r.misaligned;
            wb_next_s.bus_error      = timeout_s;
            wb_next_s.write_register = m_r.write_register;
            wb_next_s.alu_result     = m_r.alu_result;
            if (load_done_s) begin
                wb_next_s.read_data = Mem_Rdata;
            end else begin
                wb_next_s.read_data = wb_r.read_data;
            end
        end else begin
            wb_next_s.valid = 1'b0;
        end
    end

    // MEM/WB register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wb_r <= WB_RESET;
        end else begin
            wb_r <= wb_next_s;
        end
    end

    assign Stall_MEM          = stall_s;
    assign Mem_Req            = busy_s;
    assign Mem_We             = busy_s & m_r.mem_write;
    assign Mem_Addr           = {m_r.alu_result[31:2], 2'b00};
    assign Mem_Wdata          = m_r.write_data;
    assign Valid_MEM          = wb_r.valid;
    assign RegWrite_MEM       = wb_r.reg_write;
    assign MemtoReg_MEM       = wb_r.mem_to_reg;
    assign ALU_Result_MEM     = wb_r.alu_result;
    assign Read_Data_MEM      = wb_r.read_data;
    assign Write_Register_MEM = wb_r.write_register;
    assign Misaligned_MEM     = wb_r.misaligned;
    assign Bus_Error_MEM      = wb_r.bus_error;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage directly downstream of the EX ALU: registers the EX-stage bundle (ALU result, store data, destination register, control bits), performs the load/store against a variable-latency data memory over a req/ack handshake, and presents a registered MEM/WB bundle to writeback. Memory wait states stall the upstream pipeline. Misaligned word accesses and unacknowledged requests are trapped as faults.

## Interface
Parameters:
- TIMEOUT, 16 — maximum cycles Mem_Req is held without Mem_Ack before a bus-error retire; legal range 2..255.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Valid_EX  in  1  EX bundle is a real instruction (0 = bubble).
- ALU_Result_EX  in  32  ALU result, used as the memory byte address for loads/stores.
- Write_Data_EX  in  32  store data.
- Write_Register_EX  in  5  destination register.
- MemRead_EX, MemWrite_EX, RegWrite_EX, MemtoReg_EX  in  1 each  control bits; MemRead and MemWrite are never both 1.
- Stall_MEM  out  1  upstream must hold its EX bundle this cycle.
- Mem_Req  out  1  memory request.
- Mem_We  out  1  1 = write.
- Mem_Addr  out  32  word-aligned byte address.
- Mem_Wdata  out  32  write data.
- Mem_Rdata  in  32  read data, valid when Mem_Ack = 1.
- Mem_Ack  in  1  transfer completes in any cycle with Mem_Req & Mem_Ack.
- Valid_MEM, RegWrite_MEM, MemtoReg_MEM  out  1 each  registered writeback controls.
- ALU_Result_MEM, Read_Data_MEM  out  32  registered ALU result / load data.
- Write_Register_MEM  out  5  registered destination.
- Misaligned_MEM, Bus_Error_MEM  out  1 each  one-cycle fault flags, aligned with Valid_MEM.

## Operation
- Internal M register holds the in-flight instruction; it loads the EX bundle (or a bubble if Valid_EX = 0) on every edge with Stall_MEM = 0, and holds otherwise.
- FSM states: IDLE, BUSY.
  - IDLE -> BUSY at a capture edge when the captured bundle is a valid, aligned memory op.
  - BUSY -> BUSY when Mem_Ack and the next captured bundle is again a valid, aligned memory op.
  - BUSY -> IDLE on Mem_Ack otherwise, or on timeout.
- Mem_Req = (state == BUSY). Mem_We, Mem_Addr and Mem_Wdata come from the M register and are stable while Mem_Req is held.
- Stall_MEM = BUSY & ~Mem_Ack.
- Retire: the MEM/WB register loads from M on each non-stalled edge.
  - Read_Data_MEM = Mem_Rdata for loads; otherwise it holds its previous value.
  - A bubble retires with Valid_MEM = 0 and all controls 0.
- Misaligned: a valid mem op with ALU_Result_EX[1:0] != 0 stays IDLE and issues no request. It retires on the next edge with Misaligned_MEM = 1 and RegWrite_MEM = 0.
- Timeout: a counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT-1 with no ack, the instruction retires at that edge with Bus_Error_MEM = 1 and RegWrite_MEM = 0; Stall_MEM is low that cycle.
  - Ack in the threshold cycle wins: normal retire.
- Address arithmetic: Mem_Addr = {ALU_Result[31:2], 2'b00}. No sign or width extension.

## Timing
- Reset (asynchronous, immediate): state IDLE, counter 0, M = bubble, Mem_Req 0, Stall_MEM 0, every MEM output 0. Reset mid-request drops Mem_Req in the same cycle; a late Mem_Ack is ignored.
- Non-memory op captured at edge N: WB outputs valid after edge N+1.
- Memory op captured at edge N: Mem_Req high from N; with k wait cycles, the op retires at edge N+1+k.
- Back-to-back memory ops with zero-wait memory: Mem_Req stays high continuously, one transfer per cycle, and Stall_MEM is never raised.
- Fault flags are high for exactly one cycle, coincident with Valid_MEM.

## Structure
- Shared package `mips_pkg`: FSM state enum and the MEM/WB bundle struct (also consumed by the writeback stage).
- One sub-module, `mem_wait_fsm`: state register, timeout counter, Mem_Req/Stall_MEM generation. Its inputs are capture-valid/aligned-mem and Mem_Ack; its outputs are busy, stall and timeout.
- The top level holds the M and MEM/WB registers.

## Test plan
- ALU op, ALU_Result_EX = 0x0000_0005, RegWrite = 1 -> one edge later Valid_MEM = 1, ALU_Result_MEM = 5, no Mem_Req.
- Load at 0x100, memory acks after 3 wait cycles with 0xDEAD_BEEF -> Stall_MEM high 3 cycles, Mem_Addr = 0x100, Read_Data_MEM = 0xDEAD_BEEF, MemtoReg_MEM = 1.
- Store 0x1234 to 0x104, then load 0x108, zero-wait ack -> Mem_Req continuous for 2 cycles, first cycle Mem_We = 1, no stall.
- Load at 0x102 -> no Mem_Req, Misaligned_MEM = 1 for one cycle, RegWrite_MEM = 0.
- TIMEOUT = 4, no ack -> Mem_Req for 4 cycles then drops, Bus_Error_MEM = 1; a repeat run with ack in cycle 4 retires normally with no error.
- Reset_n pulsed low while BUSY -> Mem_Req and all outputs 0 immediately; the next load after release issues cleanly.
